// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and status flag bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NAND = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_XNOR = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_INC  = 4'd10,
        ALU_DEC  = 4'd11,
        ALU_BUF  = 4'd12,
        ALU_BUB  = 4'd13,
        ALU_NOT  = 4'd14,
        ALU_NOB  = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic neg;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, command, enable) -> 2*WIDTH-bit result + flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the surrounding pipeline decides when results are captured.
// Ports: i_a/i_b operands, i_command opcode, i_enable (0 forces zero result),
//        o_y result, o_flags {zero, carry, neg}.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [3:0]         i_command,
    input  logic               i_enable,
    output logic [2*WIDTH-1:0] o_y,
    output alu_flags_t         o_flags
);

    localparam int RW = 2 * WIDTH;

    logic [RW-1:0] w_a_ext;
    logic [RW-1:0] w_b_ext;
    logic [RW-1:0] w_one;
    logic [RW-1:0] w_res;
    logic          w_carry;
    logic [RW-1:0] w_y;

    assign w_a_ext = {{WIDTH{1'b0}}, i_a};
    assign w_b_ext = {{WIDTH{1'b0}}, i_b};
    assign w_one   = {{(RW-1){1'b0}}, 1'b1};

    // Logical ops work on WIDTH bits and are zero-extended; arithmetic wraps in RW bits.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (alu_op_e'(i_command))
            ALU_ADD:  begin
                w_res   = w_a_ext + w_b_ext;
                w_carry = w_res[WIDTH];
            end
            ALU_SUB:  begin
                w_res   = w_a_ext - w_b_ext;
                w_carry = (i_a < i_b);
            end
            ALU_AND:  w_res = {{WIDTH{1'b0}}, i_a & i_b};
            ALU_OR:   w_res = {{WIDTH{1'b0}}, i_a | i_b};
            ALU_XOR:  w_res = {{WIDTH{1'b0}}, i_a ^ i_b};
            ALU_NAND: w_res = {{WIDTH{1'b0}}, ~(i_a & i_b)};
            ALU_NOR:  w_res = {{WIDTH{1'b0}}, ~(i_a | i_b)};
            ALU_XNOR: w_res = {{WIDTH{1'b0}}, ~(i_a ^ i_b)};
            ALU_SHL:  begin
                w_res   = w_a_ext << 1;
                w_carry = i_a[WIDTH-1];
            end
            ALU_SHR:  begin
                w_res   = w_a_ext >> 1;
                w_carry = i_a[0];
            end
            ALU_INC:  begin
                w_res   = w_a_ext + w_one;
                w_carry = w_res[WIDTH];
            end
            ALU_DEC:  begin
                w_res   = w_a_ext - w_one;
                w_carry = (i_a == '0);
            end
            ALU_BUF:  w_res = w_a_ext;
            ALU_BUB:  w_res = w_b_ext;
            ALU_NOT:  w_res = {{WIDTH{1'b0}}, ~i_a};
            ALU_NOB:  w_res = {{WIDTH{1'b0}}, ~i_b};
            default:  w_res = '0;
        endcase
    end

    // A disabled beat still flows through the pipe but reports an all-zero result.
    assign w_y           = i_enable ? w_res : '0;
    assign o_y           = w_y;
    assign o_flags.zero  = (w_y == '0);
    assign o_flags.carry = i_enable & w_carry;
    assign o_flags.neg   = w_y[RW-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers operands, S2 registers result and flags.
// Latency: result valid after the second edge following accept; one beat per cycle.
// Backpressure: out_ready=0 freezes S2; S1 holds when full; in_ready drops with both full.
// Ports: clk, rst_n (async low); in_valid/in_ready, a, b, command, enable in;
//        out_valid/out_ready, y, flag_zero, flag_carry, flag_neg out.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         command,
    input  logic               enable,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_neg
);

    logic               r_s1_vld;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [3:0]         r_s1_cmd;
    logic               r_s1_en;

    logic               r_s2_vld;
    logic [2*WIDTH-1:0] r_y;
    alu_flags_t         r_flags;

    logic               w_s2_adv;
    logic [2*WIDTH-1:0] w_core_y;
    alu_flags_t         w_core_flags;

    // S2 may load whenever it is empty or its beat leaves this cycle; S1 may
    // load whenever it is empty or its beat moves into S2.
    assign w_s2_adv = !r_s2_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s2_adv;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .i_command (r_s1_cmd),
        .i_enable  (r_s1_en),
        .o_y       (w_core_y),
        .o_flags   (w_core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_cmd <= '0;
            r_s1_en  <= 1'b0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_a   <= a;
                r_s1_b   <= b;
                r_s1_cmd <= command;
                r_s1_en  <= enable;
            end
        end
    end

    // Data registers only load on a real beat so y stays put across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_y      <= '0;
            r_flags  <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_y     <= w_core_y;
                r_flags <= w_core_flags;
            end
        end
    end

    assign out_valid  = r_s2_vld;
    assign y          = r_y;
    assign flag_zero  = r_flags.zero;
    assign flag_carry = r_flags.carry;
    assign flag_neg   = r_flags.neg;

endmodule
